// File: rtl/pid_cfg_master_pkg.sv
// Shared definitions for the PID configuration Wishbone master: FSM encoding,
// PID register word offsets and the per-beat byte stride.
package pid_cfg_master_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StStb  = 4'b0010,
    StGap  = 4'b0100,
    StFin  = 4'b1000
  } state_e;

  localparam int unsigned KpIdx = 0;
  localparam int unsigned KiIdx = 1;
  localparam int unsigned KdIdx = 2;
  localparam int unsigned SvIdx = 3;

  function automatic int unsigned byte_stride(input int unsigned wb_nb);
    return wb_nb / 8;
  endfunction

endpackage

// File: rtl/pid_cfg_beat_gen.sv
// Beat sequencer: holds the beat index and the current beat byte address.
module pid_cfg_beat_gen
  import pid_cfg_master_pkg::*;
#(
  parameter int unsigned WB_NB     = 32,
  parameter int unsigned ADR_WB_NB = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADR_WB_NB-1:0] i_base,
  input  logic [1:0]           i_len,
  input  logic                 i_advance,
  output logic [ADR_WB_NB-1:0] o_adr,
  output logic [1:0]           o_idx,
  output logic                 o_last
);

  localparam logic [ADR_WB_NB-1:0] Stride = ADR_WB_NB'(byte_stride(WB_NB));

  logic [ADR_WB_NB-1:0] r_adr;
  logic [1:0]           r_idx;
  logic [1:0]           r_len;

  // Address adds wrap naturally at the address width.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_adr <= '0;
      r_idx <= '0;
      r_len <= '0;
    end else if (i_start) begin
      r_adr <= i_base;
      r_idx <= '0;
      r_len <= i_len;
    end else if (i_advance) begin
      r_adr <= r_adr + Stride;
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_adr  = r_adr;
  assign o_idx  = r_idx;
  assign o_last = (r_idx == r_len);

endmodule

// File: rtl/pid_cfg_master.sv
// Wishbone Classic initiator issuing 1..4 beat PID configuration commands.
// Optional ack watchdog enabled by defining PID_CFG_MASTER_TIMEOUT_EN.
module pid_cfg_master
  import pid_cfg_master_pkg::*;
#(
  parameter int unsigned WB_NB       = 32,
  parameter int unsigned ADR_WB_NB   = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [ADR_WB_NB-1:0] i_cmd_adr,
  input  logic [1:0]           i_cmd_len,
  input  logic [63:0]          i_cmd_data,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADR_WB_NB-1:0] o_wb_adr,
  output logic [WB_NB-1:0]     o_wb_data,
  input  logic [WB_NB-1:0]     i_wb_data,
  input  logic                 i_wb_ack,
  output logic                 o_rd_valid,
  output logic [WB_NB-1:0]     o_rd_data,
  output logic [1:0]           o_rd_idx,
  output logic                 o_done,
  output logic                 o_err
);

  state_e                 r_state;
  state_e                 w_state_d;
  logic                   r_we;
  logic [63:0]            r_data;
  logic                   r_rd_valid;
  logic [WB_NB-1:0]       r_rd_data;
  logic [1:0]             r_rd_idx;

  logic                   w_start;
  logic                   w_advance;
  logic                   w_in_stb;
  logic                   w_rd_capture;
  logic                   w_timeout;
  logic [ADR_WB_NB-1:0]   w_adr;
  logic [1:0]             w_idx;
  logic                   w_last;
  logic [15:0]            w_word;
  logic [WB_NB-1:0]       w_wdata;

  pid_cfg_beat_gen #(
    .WB_NB    (WB_NB),
    .ADR_WB_NB(ADR_WB_NB)
  ) u_beat_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_base   (i_cmd_adr),
    .i_len    (i_cmd_len),
    .i_advance(w_advance),
    .o_adr    (w_adr),
    .o_idx    (w_idx),
    .o_last   (w_last)
  );

  assign w_word = r_data[{w_idx, 4'b0000} +: 16];

  if (WB_NB == 16) begin : g_wdata_narrow
    assign w_wdata = w_word;
  end else begin : g_wdata_ext
    assign w_wdata = {{(WB_NB - 16){w_word[15]}}, w_word};
  end

`ifdef PID_CFG_MASTER_TIMEOUT_EN
  localparam logic [7:0] ToLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_to_cnt;
  logic       r_to_err;

  assign w_timeout = (r_state == StStb) && !i_wb_ack && (r_to_cnt == ToLast);

  // Counter is zero on every STB entry since it clears outside STB.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == StStb) ? r_to_cnt + 8'd1 : 8'd0;
      if (w_start) begin
        r_to_err <= 1'b0;
      end else if (w_timeout) begin
        r_to_err <= 1'b1;
      end
    end
  end

  assign o_err = (r_state == StFin) && r_to_err;
`else
  logic w_unused_to;

  assign w_timeout   = 1'b0;
  assign w_unused_to = ^8'(TIMEOUT_CYC);
  assign o_err       = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_advance = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_start   = 1'b1;
          w_state_d = StStb;
        end
      end
      StStb: begin
        if (i_wb_ack) begin
          w_state_d = StGap;
        end else if (w_timeout) begin
          w_state_d = StFin;
        end
      end
      StGap: begin
        if (w_last) begin
          w_state_d = StFin;
        end else begin
          w_advance = 1'b1;
          w_state_d = StStb;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_in_stb     = (r_state == StStb);
  assign w_rd_capture = w_in_stb && i_wb_ack && !r_we;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_data     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_idx   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rd_valid <= w_rd_capture;
      if (w_start) begin
        r_we   <= i_cmd_we;
        r_data <= i_cmd_data;
      end
      if (w_rd_capture) begin
        r_rd_data <= i_wb_data;
        r_rd_idx  <= w_idx;
      end
    end
  end

  // Ready is masked by reset because the async reset parks the FSM in IDLE.
  assign o_cmd_ready = (r_state == StIdle) && i_rst;
  assign o_wb_cyc    = (r_state == StStb) || (r_state == StGap);
  assign o_wb_stb    = w_in_stb;
  assign o_wb_we     = w_in_stb && r_we;
  assign o_wb_adr    = w_in_stb ? w_adr : '0;
  assign o_wb_data   = w_in_stb ? w_wdata : '0;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_rd_idx    = r_rd_idx;
  assign o_done      = (r_state == StFin);

endmodule

// File: tb/tb_pid_cfg_master.sv
// Directed bench for pid_cfg_master: 32-bit instance against a PID register
// responder model plus a 16-bit instance for address wrap and data width.
module tb_pid_cfg_master;
  import pid_cfg_master_pkg::*;

  localparam int unsigned To = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 32-bit instance
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [1:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready, wb_cyc, wb_stb, wb_we, wb_ack;
  logic [15:0] wb_adr;
  logic [31:0] wb_dout, wb_din, rd_data;
  logic        rd_valid, done, err;
  logic [1:0]  rd_idx;

  // 16-bit instance
  logic        h_valid = 1'b0, h_we = 1'b0;
  logic [15:0] h_cadr = '0;
  logic [1:0]  h_len = '0;
  logic [63:0] h_cdata = '0;
  logic        h_ready, h_cyc, h_stb, h_wbwe, h_ack;
  logic [15:0] h_adr, h_dout, h_din, h_rdata;
  logic        h_rvalid, h_done, h_err;
  logic [1:0]  h_ridx;

  pid_cfg_master #(.WB_NB(32), .ADR_WB_NB(16), .TIMEOUT_CYC(To)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_adr(cmd_adr), .i_cmd_len(cmd_len), .i_cmd_data(cmd_data),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_data(wb_dout), .i_wb_data(wb_din), .i_wb_ack(wb_ack),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_idx(rd_idx),
    .o_done(done), .o_err(err)
  );

  pid_cfg_master #(.WB_NB(16), .ADR_WB_NB(16), .TIMEOUT_CYC(To)) dut16 (
    .i_clk(clk), .i_rst(rst_n),
    .i_cmd_valid(h_valid), .o_cmd_ready(h_ready), .i_cmd_we(h_we),
    .i_cmd_adr(h_cadr), .i_cmd_len(h_len), .i_cmd_data(h_cdata),
    .o_wb_cyc(h_cyc), .o_wb_stb(h_stb), .o_wb_we(h_wbwe), .o_wb_adr(h_adr),
    .o_wb_data(h_dout), .i_wb_data(h_din), .i_wb_ack(h_ack),
    .o_rd_valid(h_rvalid), .o_rd_data(h_rdata), .o_rd_idx(h_ridx),
    .o_done(h_done), .o_err(h_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PID register responder: ack on the third STB cycle, idle again only on stb low.
  logic [31:0] mem [4];
  logic        r_ph, r_busy;
  logic        resp_en = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack <= 1'b0; r_ph <= 1'b0; r_busy <= 1'b0; wb_din <= '0;
    end else begin
      wb_ack <= 1'b0;
      if (!wb_stb) begin
        r_busy <= 1'b0; r_ph <= 1'b0;
      end else if (resp_en && !r_busy) begin
        if (!r_ph) r_ph <= 1'b1;
        else begin
          wb_ack <= 1'b1; r_busy <= 1'b1; r_ph <= 1'b0;
          if (wb_we) mem[wb_adr[3:2]] <= wb_dout;
          else wb_din <= mem[wb_adr[3:2]];
        end
      end
    end
  end

  logic h_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_ack <= 1'b0; h_busy <= 1'b0; h_din <= '0;
    end else begin
      h_ack <= 1'b0;
      if (!h_stb) h_busy <= 1'b0;
      else if (!h_busy) begin
        h_ack <= 1'b1; h_busy <= 1'b1; h_din <= h_adr ^ 16'h5A5A;
      end
    end
  end

  typedef struct packed {logic we; logic [15:0] adr; logic [31:0] data;} beat_t;
  typedef struct packed {logic [1:0] idx; logic [31:0] data;} rd_t;
  beat_t exp_beats[$];
  rd_t   exp_rd[$];
  beat_t exp16[$];
  rd_t   exp_rd16[$];
  beat_t mb, hb;
  rd_t   mr, hr;
  logic  ack_prev = 1'b0, stb_prev = 1'b0;
  int    stb_rises = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (ack_prev) check("stb_gap", wb_stb, 1'b0);
    ack_prev = wb_stb && wb_ack;
    if (wb_stb && !stb_prev) stb_rises++;
    stb_prev = wb_stb;
    if (done) done_cnt++;
    if (wb_stb && wb_ack) begin
      if (exp_beats.size() == 0) check("beat_unexpected", 1'b1, 1'b0);
      else begin
        mb = exp_beats.pop_front();
        check("beat_we", wb_we, mb.we);
        check("beat_adr", wb_adr, mb.adr);
        if (mb.we) check("beat_wdata", wb_dout, mb.data);
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
      else begin
        mr = exp_rd.pop_front();
        check("rd_idx", rd_idx, mr.idx);
        check("rd_data", rd_data, mr.data);
      end
    end
    if (h_stb && h_ack) begin
      if (exp16.size() == 0) check("h_beat_unexpected", 1'b1, 1'b0);
      else begin
        hb = exp16.pop_front();
        check("h_beat_we", h_wbwe, hb.we);
        check("h_beat_adr", h_adr, hb.adr);
        if (hb.we) check("h_beat_wdata", h_dout, hb.data[15:0]);
      end
    end
    if (h_rvalid) begin
      if (exp_rd16.size() == 0) check("h_rd_unexpected", 1'b1, 1'b0);
      else begin
        hr = exp_rd16.pop_front();
        check("h_rd_idx", h_ridx, hr.idx);
        check("h_rd_data", h_rdata, hr.data[15:0]);
      end
    end
  end

  task automatic send32(input logic we, input logic [15:0] adr, input logic [1:0] len,
                        input logic [63:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the o_done cycle; lat counts from the cycle after acceptance as 1.
  task automatic wait_done32(input logic exp_err, output int lat, output int rd_at,
                             output int cyc_low, output int stb_hi);
    lat = 1; rd_at = 0; cyc_low = 0; stb_hi = 0;
    while (!done && lat < 200) begin
      if (rd_valid) rd_at = lat;
      if (!wb_cyc) cyc_low++;
      if (wb_stb) stb_hi++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1'b1);
    if (done) check("done_err", err, exp_err);
  endtask

  task automatic wait_done16();
    int n = 0;
    while (!h_done && n < 100) begin @(negedge clk); n++; end
    check("h_done_seen", h_done, 1'b1);
    check("h_err", h_err, 1'b0);
    @(negedge clk);
    check("h_cyc_after", h_cyc, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd_at, cyc_low, stb_hi, rises0, dones0, n;

    // Reset state
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_wb", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dout}, '0);
    check("rst_out", {rd_valid, done, err}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // Block write of four beats with sign extension on the last word
    exp_beats.push_back('{1'b1, 16'h0000, 32'h0000_0100});
    exp_beats.push_back('{1'b1, 16'h0004, 32'h0000_0200});
    exp_beats.push_back('{1'b1, 16'h0008, 32'h0000_0300});
    exp_beats.push_back('{1'b1, 16'h000C, 32'hFFFF_8000});
    rises0 = stb_rises; dones0 = done_cnt;
    send32(1'b1, 16'h0000, 2'd3, {16'h8000, 16'h0300, 16'h0200, 16'h0100});
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    check("blk_cyc_low", cyc_low, 0);
    check("blk_stb_pulses", stb_rises - rises0, 4);
    @(negedge clk);
    check("blk_one_done", done_cnt - dones0, 1);
    check("blk_beats_left", exp_beats.size(), 0);

    // kp write then readback from the same register
    exp_beats.push_back('{1'b1, 16'(KpIdx * 4), 32'h0000_0010});
    send32(1'b1, 16'(KpIdx * 4), 2'd0, 64'h0010);
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    check("single_wr_latency", lat, 5);
    exp_beats.push_back('{1'b0, 16'(KpIdx * 4), 32'h0});
    exp_rd.push_back('{2'd0, 32'h0000_0010});
    send32(1'b0, 16'(KpIdx * 4), 2'd0, 64'h0);
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    check("kp_rd_latency", lat, 5);

    // Single read of 0x7B from kd, done one cycle after the read result
    exp_beats.push_back('{1'b1, 16'(KdIdx * 4), 32'h0000_007B});
    send32(1'b1, 16'h0008, 2'd0, 64'h007B);
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    exp_beats.push_back('{1'b0, 16'h0008, 32'h0});
    exp_rd.push_back('{2'd0, 32'h0000_007B});
    send32(1'b0, 16'h0008, 2'd0, 64'h0);
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    check("rd_to_done", lat - rd_at, 1);

    // Command held valid while busy must not be queued
    exp_beats.push_back('{1'b0, 16'h0004, 32'h0});
    exp_rd.push_back('{2'd0, 32'h0000_0200});
    rises0 = stb_rises;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h0004; cmd_len = 2'd0;
    @(negedge clk);
    check("busy_ready", cmd_ready, 1'b0);
    cmd_we = 1'b1; cmd_adr = 16'h000C;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
    repeat (6) @(negedge clk);
    check("busy_no_queue", stb_rises - rises0, 1);

    // Reset during STB of the second beat of a block write
    exp_beats.push_back('{1'b1, 16'h0000, 32'h0000_1111});
    dones0 = done_cnt;
    send32(1'b1, 16'h0000, 2'd3, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    n = 0;
    while (!(wb_stb && wb_adr == 16'h0004) && n < 40) begin @(negedge clk); n++; end
    check("beat2_reached", wb_adr, 16'h0004);
    rst_n = 1'b0;
    #1;
    check("abort_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", cmd_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - dones0, 0);

`ifdef PID_CFG_MASTER_TIMEOUT_EN
    // Silent responder: watchdog ends the command with done and err
    resp_en = 1'b0;
    send32(1'b0, 16'h0000, 2'd1, 64'h0);
    wait_done32(1'b1, lat, rd_at, cyc_low, stb_hi);
    check("to_stb_cycles", stb_hi, To);
    resp_en = 1'b1;
    exp_beats.push_back('{1'b0, 16'h0000, 32'h0});
    exp_rd.push_back('{2'd0, 32'h0000_1111});
    send32(1'b0, 16'h0000, 2'd0, 64'h0);
    wait_done32(1'b0, lat, rd_at, cyc_low, stb_hi);
`endif

    // 16-bit bus: address wrap and unextended write word
    exp16.push_back('{1'b0, 16'hFFFE, 32'h0});
    exp16.push_back('{1'b0, 16'h0000, 32'h0});
    exp_rd16.push_back('{2'd0, 32'h0000_A5A4});
    exp_rd16.push_back('{2'd1, 32'h0000_5A5A});
    @(negedge clk);
    check("h_ready", h_ready, 1'b1);
    h_valid = 1'b1; h_we = 1'b0; h_cadr = 16'hFFFE; h_len = 2'd1; h_cdata = '0;
    @(negedge clk);
    h_valid = 1'b0;
    wait_done16();
    exp16.push_back('{1'b1, 16'h0010, 32'h0000_8000});
    h_valid = 1'b1; h_we = 1'b1; h_cadr = 16'h0010; h_len = 2'd0; h_cdata = 64'h8000;
    @(negedge clk);
    h_valid = 1'b0;
    wait_done16();

    repeat (3) @(negedge clk);
    check("beats_drained", exp_beats.size() + exp_rd.size(), 0);
    check("h_drained", exp16.size() + exp_rd16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
